// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the UART configuration frame: header bytes, reset
// defaults, stop-bit code mapping and the frame byte selector.
package uart_cfg_pkg;

  localparam logic [7:0] CFG_HEAD0 = 8'hEE;
  localparam logic [7:0] CFG_HEAD1 = 8'hDD;
  localparam logic [7:0] CFG_HEAD2 = 8'hCC;
  localparam int         FRAME_LEN = 13;

  localparam logic        RST_PARITY   = 1'b0;
  localparam logic [1:0]  RST_STOPBIT  = 2'b11;
  localparam logic [31:0] RST_INTERVAL = 32'd0;
  localparam logic [31:0] RST_BAUD     = 32'd115200;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  typedef struct packed {
    logic        parity;
    logic [1:0]  stopbit;
    logic [31:0] interval;
    logic [31:0] baud;
  } cfg_t;

  localparam cfg_t RST_CFG = '{parity: RST_PARITY, stopbit: RST_STOPBIT,
                               interval: RST_INTERVAL, baud: RST_BAUD};

  function automatic logic [7:0] stop_to_code(input logic [1:0] s);
    case (s)
      2'b11:   return 8'h01;
      2'b10:   return 8'h02;
      2'b01:   return 8'h03;
      default: return 8'h04;
    endcase
  endfunction

  // Unknown codes fall back to the reset stop-bit setting.
  function automatic logic [1:0] code_to_stop(input logic [7:0] c);
    case (c)
      8'h01:   return 2'b11;
      8'h02:   return 2'b10;
      8'h03:   return 2'b01;
      8'h04:   return 2'b00;
      default: return RST_STOPBIT;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input cfg_t c, input logic [3:0] idx,
                                            input logic [7:0] h0, input logic [7:0] h1,
                                            input logic [7:0] h2);
    case (idx)
      4'd0:    return h0;
      4'd1:    return h1;
      4'd2:    return h2;
      4'd3:    return {7'b0, c.parity};
      4'd4:    return stop_to_code(c.stopbit);
      4'd5:    return c.interval[31:24];
      4'd6:    return c.interval[23:16];
      4'd7:    return c.interval[15:8];
      4'd8:    return c.interval[7:0];
      4'd9:    return c.baud[31:24];
      4'd10:   return c.baud[23:16];
      4'd11:   return c.baud[15:8];
      4'd12:   return c.baud[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_cfg_report.sv
// Snapshots the live link configuration and streams it out as a 13-byte
// config frame on a byte-wide valid/ready interface.
module uart_cfg_report
  import uart_cfg_pkg::*;
#(
  parameter logic [7:0] HEAD0       = CFG_HEAD0,
  parameter logic [7:0] HEAD1       = CFG_HEAD1,
  parameter logic [7:0] HEAD2       = CFG_HEAD2,
  parameter int         GAP_CYCLES  = 0,
  parameter bit         AUTO_REPORT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        parity,
  input  logic [1:0]  stopbit,
  input  logic [31:0] interval,
  input  logic [31:0] baud,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state, state_n;
  cfg_t          snap, last, cur;
  logic [3:0]    idx;
  logic [GW-1:0] gcnt;
  logic          pending, start, accept, last_byte;

  assign cur       = '{parity: parity, stopbit: stopbit, interval: interval, baud: baud};
  assign accept    = (state == SEND) && tx_ready;
  assign last_byte = (idx == 4'(FRAME_LEN - 1));
  // Auto mode compares against what was last sent, so a mid-frame change
  // still produces a follow-up frame once the current one completes.
  assign start     = req || pending || (AUTO_REPORT && (cur != last));

  assign tx_valid = (state == SEND);
  assign tx_data  = tx_valid ? frame_byte(snap, idx, HEAD0, HEAD1, HEAD2) : 8'h00;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = SEND;
      SEND: begin
        if (accept) begin
          if (last_byte)            state_n = IDLE;
          else if (GAP_CYCLES == 0) state_n = SEND;
          else                      state_n = GAP;
        end
      end
      GAP:     if (gcnt == '0) state_n = SEND;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap    <= RST_CFG;
      last    <= RST_CFG;
      idx     <= '0;
      gcnt    <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      done  <= accept && last_byte;
      if (state == IDLE) begin
        if (start) begin
          snap    <= cur;
          idx     <= '0;
          pending <= 1'b0;
        end
      end else if (req) begin
        pending <= 1'b1;
      end
      if (accept) begin
        if (last_byte) begin
          last <= snap;
        end else begin
          idx  <= idx + 4'd1;
          gcnt <= GAP_LOAD;
        end
      end
      if (state == GAP && gcnt != '0) gcnt <= gcnt - 1'b1;
    end
  end

endmodule

// File: doc/uart_cfg_report.md
Name: uart_cfg_report

Overview:
Transmit-side counterpart of the UART configuration frame parser. On request, it snapshots the active link configuration (parity, stop bits, interval, baud) and serialises it as a 13-byte frame onto a byte-wide valid/ready stream feeding the UART TX path. The frame format is byte-exact with the inbound config command, so a host can read back the settings or loop them back. It sits between the config register outputs and the UART byte transmitter.

Parameters:
HEAD0, 8'hEE, first header byte
HEAD1, 8'hDD, second header byte
HEAD2, 8'hCC, third header byte
GAP_CYCLES, 0, idle cycles forced between accepted bytes (0 = back-to-back)
AUTO_REPORT, 0, 1 = start a frame automatically when the config inputs differ from the last reported snapshot

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req  in  1  report request, level-sampled each cycle
parity  in  1  current parity (0 odd, 1 even)
stopbit  in  2  current stop-bit code
interval  in  32  current interval setting
baud  in  32  current baud setting
tx_ready  in  1  downstream accepts byte
tx_data  out  8  frame byte
tx_valid  out  1  tx_data valid
busy  out  1  frame in progress (snapshot held)
done  out  1  one-cycle pulse on final byte accept

Behaviour:
- Reset: tx_valid=0, tx_data=0, busy=0, done=0, pending=0, byte index=0, gap counter=0, state IDLE. Last-reported snapshot resets to parity=0, stopbit=2'b11, interval=0, baud=115200, so no spurious auto-report occurs after reset.
- Frame order, 13 bytes: HEAD0, HEAD1, HEAD2, {7'b0,parity}, stop code, interval[31:24], [23:16], [15:8], [7:0], baud[31:24], [23:16], [15:8], [7:0].
- Stop code mapping: 2'b11->8'h01, 2'b10->8'h02, 2'b01->8'h03, 2'b00->8'h04.
- FSM states: IDLE, SEND, GAP.
  - IDLE: the start condition is req, or pending, or (AUTO_REPORT and inputs != last snapshot). At the edge where it holds: snapshot all four inputs, index=0, pending cleared. Next state SEND with tx_valid=1 and tx_data=HEAD0 visible after that edge. Latency req->first tx_valid is 1 cycle.
  - SEND: tx_data and tx_valid hold stable while tx_ready=0. A byte is accepted on tx_valid&&tx_ready.
    - Non-final accept: index+1. If GAP_CYCLES=0, stay in SEND with the next byte valid on the next cycle. Otherwise go to GAP with tx_valid=0.
    - Final accept (index 12): done=1 for one cycle, tx_valid=0, busy=0, update the last-reported snapshot, state IDLE. The GAP delay is not applied after the last byte.
  - GAP: count GAP_CYCLES cycles with tx_valid=0, then return to SEND presenting the next byte.
- busy=1 in SEND and GAP.
- The snapshot is frozen for the whole frame. Input changes mid-frame do not alter the bytes. In AUTO_REPORT mode such a change triggers a new frame afterward, because the inputs differ from the updated last snapshot.
- req while busy sets pending; multiple requests collapse to one. The pending frame starts from IDLE on the cycle after done, so there is a minimum 1 idle cycle between frames.
- Simultaneous final accept and req: pending set, and the next frame starts after the IDLE cycle.
- tx_ready asserted while tx_valid=0 is ignored.
- Reset mid-frame clears all state immediately. There is no partial-frame completion.
- Width rules: index is 4 bits, range 0..12. The gap counter width is clog2(GAP_CYCLES+1), minimum 1.

Decomposition:
- Shared package uart_cfg_pkg holds:
  - header byte constants
  - FRAME_LEN=13
  - reset defaults (parity 0, stopbit 2'b11, interval 0, baud 115200)
  - stopbit<->code mapping functions, reused by the parser
  - FSM state typedef
- No sub-module needed. The byte select is a 13-way mux function in the package.

Test Plan:
- parity=1, stopbit=2'b10, interval=32'h0000_03E8, baud=32'd9600, tx_ready=1, req pulse -> bytes EE DD CC 01 02 00 00 03 E8 00 00 25 80 on 13 consecutive cycles, done pulse on the 13th accept, busy low after.
- Same frame with tx_ready toggled 1/0 randomly -> tx_data/tx_valid stable during stalls, byte sequence identical, no drops or duplicates.
- GAP_CYCLES=3 -> exactly 3 tx_valid=0 cycles between each accepted byte, none after byte 13.
- Change baud to 57600 at byte 5, and pulse req 3 times mid-frame -> current frame carries old baud; exactly one further frame follows, starting after a 1-cycle IDLE, carrying baud 00 00 E1 00.
- AUTO_REPORT=1: no activity after reset with default inputs; change stopbit to 2'b00 -> one frame with stop code 04, then silence.
- Assert rst_n=0 at byte 7 -> tx_valid, busy, done drop immediately; no output after release until a new req.
